// File: rtl/adc128s.sv
// SPI slave model of an 8-channel 12-bit A2D converter, sampled in the clk domain.
// Optional macro ADC128S_TRISTATE_EN: MISO floats while the registered SS_n is high.
module adc128s #(
  parameter logic [11:0] INIT_VAL  = 12'hC00,
  parameter logic [11:0] CH_OFFSET = 12'h010,
  parameter logic [11:0] STEP      = 12'h010
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned PAD_W   = FRAME_W - DATA_W;

  logic               ss_prev;
  logic               sclk_prev;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
  logic [FRAME_W-1:0] tx, tx_d;
  logic [FRAME_W-1:0] rx, rx_d, rx_next;
  logic [CH_W-1:0]    sel_ch, sel_ch_d;
  logic [DATA_W-1:0]  ch_val   [NUM_CH];
  logic [DATA_W-1:0]  ch_val_d [NUM_CH];
  logic               miso_q, miso_d;
  logic               sclk_rise, sclk_fall, ss_fall, active;
  logic               cnt_lt_frame, cnt_nonzero, last_rise;

  assign sclk_rise    = SCLK & ~sclk_prev;
  assign sclk_fall    = ~SCLK & sclk_prev;
  assign ss_fall      = ~SS_n & ss_prev;
  assign active       = ~SS_n;
  assign rx_next      = {rx[FRAME_W-2:0], MOSI};
  assign cnt_lt_frame = bit_cnt < CNT_W'(FRAME_W);
  assign cnt_nonzero  = bit_cnt != '0;
  assign last_rise    = bit_cnt == CNT_W'(FRAME_W - 1);

  // Next-state: SS_n fall has priority over any coincident SCLK edge.
  always_comb begin
    bit_cnt_d = bit_cnt;
    tx_d      = tx;
    rx_d      = rx;
    sel_ch_d  = sel_ch;
    miso_d    = miso_q;
    for (int i = 0; i < NUM_CH; i++) ch_val_d[i] = ch_val[i];

    if (ss_fall) begin
      tx_d      = {PAD_W'(0), ch_val[sel_ch]};
      rx_d      = '0;
      bit_cnt_d = '0;
      miso_d    = tx_d[FRAME_W-1];
    end else if (!active) begin
      // Aborted or finished frame: partial command is dropped.
      rx_d   = '0;
      miso_d = 1'b0;
    end else if (sclk_rise && cnt_lt_frame) begin
      rx_d      = rx_next;
      bit_cnt_d = bit_cnt + CNT_W'(1);
      if (last_rise) begin
        sel_ch_d         = rx_next[13:11];
        ch_val_d[sel_ch] = ch_val[sel_ch] + STEP;
        tx_d             = '0;
        miso_d           = 1'b0;
      end
    end else if (sclk_fall && cnt_nonzero && cnt_lt_frame) begin
      tx_d   = {tx[FRAME_W-2:0], 1'b0};
      miso_d = tx_d[FRAME_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_prev   <= 1'b1;
      sclk_prev <= 1'b1;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      sel_ch    <= '0;
      miso_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        ch_val[i] <= INIT_VAL + DATA_W'(i) * CH_OFFSET;
    end else begin
      ss_prev   <= SS_n;
      sclk_prev <= SCLK;
      bit_cnt   <= bit_cnt_d;
      tx        <= tx_d;
      rx        <= rx_d;
      sel_ch    <= sel_ch_d;
      miso_q    <= miso_d;
      for (int i = 0; i < NUM_CH; i++) ch_val[i] <= ch_val_d[i];
    end
  end

`ifdef ADC128S_TRISTATE_EN
  assign MISO = ss_prev ? 1'bz : miso_q;
`else
  assign MISO = miso_q;
`endif

endmodule

// File: tb/tb_adc128s.sv
// Scoreboard bench for adc128s: a channel model predicts every returned frame.
module tb_adc128s;

  localparam int unsigned HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n = 1'b1;
  logic SCLK = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_val [8];
  logic [2:0]  exp_sel;
  logic [15:0] exp_q [$];

  adc128s dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_val[i] = 12'hC00 + 12'(i) * 12'h010;
    exp_sel = 3'd0;
    exp_q.delete();
  endtask

  // Drive nbits SCLK periods; full frames update the model and push the expectation.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] got);
    got = 16'h0000;
    if (nbits == 16) begin
      exp_q.push_back({4'h0, exp_val[exp_sel]});
      exp_val[exp_sel] = exp_val[exp_sel] + 12'h010;
      exp_sel = cmd[13:11];
    end
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      wait_clk(HALF);
      got[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(HALF);
    end
    SS_n = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic check_frame(input string name, input logic [15:0] got);
    logic [15:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got %h but scoreboard empty", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic exp_miso;
`ifdef ADC128S_TRISTATE_EN
    exp_miso = 1'bz;
`else
    exp_miso = 1'b0;
`endif
    rst_n = 1'b0;
    wait_clk(20);
    rst_n = 1'b1;
    wait_clk(2);
    model_reset();
    n_cmp++;
    if (MISO !== exp_miso) begin
      n_bad++;
      $display("FAIL reset_miso: got %b expected %b", MISO, exp_miso);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dut.ch_val[i] !== exp_val[i]) begin
        n_bad++;
        $display("FAIL reset_ch%0d: got %h expected %h", i, dut.ch_val[i], exp_val[i]);
      end
    end
    n_cmp++;
    if (dut.sel_ch !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_sel: got %0d expected 0", dut.sel_ch);
    end
  endtask

  task automatic test_basic();
    logic [15:0] got;
    spi_frame(16'h1800, 16, got);
    check_frame("frame1_ch0", got);
    n_cmp++;
    if (dut.ch_val[0] !== 12'hC10) begin
      n_bad++;
      $display("FAIL ch0_after_read: got %h expected c10", dut.ch_val[0]);
    end
    spi_frame(16'h1800, 16, got);
    check_frame("frame2_ch3", got);
    n_cmp++;
    if (got !== 16'h0C30) begin
      n_bad++;
      $display("FAIL frame2_value: got %h expected 0c30", got);
    end
    n_cmp++;
    if (dut.ch_val[3] !== 12'hC40 || dut.sel_ch !== 3'd3) begin
      n_bad++;
      $display("FAIL ch3_sel: got ch3=%h sel=%0d expected c40/3", dut.ch_val[3], dut.sel_ch);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    spi_frame(16'h2800, 8, got);
    spi_frame(16'h0000, 16, got);
    check_frame("after_abort_ch3", got);
    n_cmp++;
    if (got !== 16'h0C40) begin
      n_bad++;
      $display("FAIL abort_retained: got %h expected 0c40", got);
    end
    spi_frame(16'h0000, 16, got);
    check_frame("after_abort_ch0", got);
  endtask

  task automatic test_ignored_sclk();
    logic [15:0] got;
    for (int i = 0; i < 6; i++) begin
      SCLK = ~SCLK;
      wait_clk(HALF);
    end
    SCLK = 1'b1;
    wait_clk(HALF);
    spi_frame(16'h3800, 16, got);
    check_frame("idle_sclk_ignored", got);
  endtask

  task automatic test_wrap();
    logic [15:0] got;
    int guard = 0;
    while (exp_val[7] != 12'hFF0 && guard < 100) begin
      spi_frame(16'h3800, 16, got);
      check_frame("ch7_ramp", got);
      guard++;
    end
    spi_frame(16'h3800, 16, got);
    check_frame("ch7_ff0", got);
    n_cmp++;
    if (got !== 16'h0FF0) begin
      n_bad++;
      $display("FAIL ch7_top: got %h expected 0ff0", got);
    end
    spi_frame(16'h3800, 16, got);
    check_frame("ch7_wrap", got);
    n_cmp++;
    if (got !== 16'h0000) begin
      n_bad++;
      $display("FAIL ch7_wrap_value: got %h expected 0000", got);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 9; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
    end
    rst_n = 1'b0;
    wait_clk(3);
    SS_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(HALF);
    model_reset();
    n_cmp++;
    if (dut.sel_ch !== 3'd0 || dut.ch_val[7] !== 12'hC70 || dut.ch_val[0] !== 12'hC00) begin
      n_bad++;
      $display("FAIL midframe_reset: got sel=%0d ch0=%h ch7=%h expected 0/c00/c70",
               dut.sel_ch, dut.ch_val[0], dut.ch_val[7]);
    end
    spi_frame(16'h0800, 16, got);
    check_frame("post_reset_ch0", got);
    n_cmp++;
    if (got !== 16'h0C00) begin
      n_bad++;
      $display("FAIL post_reset_value: got %h expected 0c00", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    logic [15:0] cmds [4];
    cmds[0] = 16'h1000; cmds[1] = 16'h2000; cmds[2] = 16'h3000; cmds[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      spi_frame(cmds[i], 16, got);
      check_frame("back_to_back", got);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_abort();
    test_ignored_sclk();
    test_wrap();
    test_reset_midframe();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
